// File: rtl/line_proc_pkg.sv
// Shared types and defaults for the line sequencer.
// Holds the FSM state encoding and the default maximum line width.
package line_proc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_WIDTH = 1600;

endpackage

// File: rtl/line_proc_sequencer_px_pack.sv
// Output pixel register: packs colour channels and the optional alpha byte.
// Used by both the kernel result path and the bypass path.
module px_pack #(
  parameter  int NCH       = 3,
  parameter  int HAS_ALPHA = 1,
  localparam int CW        = NCH * 8,
  localparam int PW        = CW + HAS_ALPHA * 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic [CW-1:0] ch,
  input  logic [7:0]    alpha,
  output logic          out_de,
  output logic [PW-1:0] out_data
);

  logic [PW-1:0] word;

  if (HAS_ALPHA != 0) begin : g_alpha
    assign word = {ch, alpha};
  end else begin : g_no_alpha
    logic unused_alpha;
    assign word = ch;
    assign unused_alpha = ^alpha;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de   <= 1'b0;
      out_data <= '0;
    end else begin
      out_de <= de;
      if (de) out_data <= word;
    end
  end

endmodule

// File: rtl/line_proc_sequencer.sv
// Line sequencer between the line-read DMA and a per-pixel kernel.
// Streams one line per ready event, counts results back, reports overruns.
module line_proc_sequencer
  import line_proc_pkg::*;
#(
  parameter  int MAX_WIDTH = DEF_WIDTH,
  parameter  int WB        = 12,
  parameter  int NCH       = 3,
  parameter  int HAS_ALPHA = 1,
  localparam int CW        = NCH * 8,
  localparam int PW        = CW + HAS_ALPHA * 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [WB-1:0] CFG_WIDTH,
  input  logic          CFG_BYPASS,
  input  logic [7:0]    CFG_ALPHA,
  input  logic          READ_LINE_DONE,
  input  logic [WB-1:0] READ_POSY,
  output logic          IN_DE,
  input  logic [PW-1:0] IN_DATA,
  output logic          K_READY,
  output logic [WB-1:0] K_POSX,
  output logic [WB-1:0] K_POSY,
  input  logic          K_RDEN,
  output logic [CW-1:0] K_IN,
  input  logic          K_WREN,
  input  logic [CW-1:0] K_OUT,
  output logic          OUT_DE,
  output logic [PW-1:0] OUT_DATA,
  output logic          WRITE_LINE_DONE,
  output logic          BUSY,
  output logic          OVERRUN
);

  localparam logic [WB-1:0] MAXW = WB'(MAX_WIDTH);

  state_t        state, state_nxt;
  logic          pend_full;
  logic [WB-1:0] pend_posy;
  logic [WB-1:0] width_q, posy_q;
  logic [WB-1:0] posx, wposx, posx_inc;
  logic          bypass_q, overrun_q;
  logic          consume, rd_act, wr_act;
  logic          res_acc, k_drop, q_drop;
  logic [WB-1:0] cfg_w;
  logic [CW-1:0] px_ch;

  assign cfg_w = (CFG_WIDTH == '0 || CFG_WIDTH > MAXW) ? MAXW : CFG_WIDTH;
  assign consume  = (state == S_IDLE) && pend_full;
  assign rd_act   = (state == S_READ);
  assign wr_act   = rd_act || (state == S_DRAIN);
  assign posx_inc = posx + 1'b1;

  assign K_READY = rd_act && !bypass_q;
  assign IN_DE   = rd_act && (posx < width_q) && (bypass_q || K_RDEN);
  assign res_acc = wr_act && (wposx < width_q)
                && (bypass_q ? IN_DE : K_WREN);
  // Any kernel result not counted as a line pixel is an overrun.
  assign k_drop  = K_WREN && !(res_acc && !bypass_q);
  assign q_drop  = READ_LINE_DONE && pend_full && !consume;

  assign K_IN            = IN_DATA[PW-1 -: CW];
  assign K_POSX          = posx;
  assign K_POSY          = posy_q;
  assign BUSY            = (state != S_IDLE);
  assign WRITE_LINE_DONE = (state == S_DONE);
  assign OVERRUN         = overrun_q;
  assign px_ch = bypass_q ? IN_DATA[PW-1 -: CW] : K_OUT;

  if (HAS_ALPHA != 0) begin : g_alpha_in
    logic unused_in;
    assign unused_in = ^IN_DATA[PW-CW-1:0];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (pend_full) state_nxt = S_READ;
      S_READ:  if (IN_DE && posx_inc == width_q) state_nxt = S_DRAIN;
      S_DRAIN: if (wposx == width_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_full <= 1'b0;
      pend_posy <= '0;
    end else if (consume) begin
      pend_full <= READ_LINE_DONE;
      if (READ_LINE_DONE) pend_posy <= READ_POSY;
    end else if (READ_LINE_DONE && !pend_full) begin
      pend_full <= 1'b1;
      pend_posy <= READ_POSY;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      width_q  <= '0;
      bypass_q <= 1'b0;
      posy_q   <= '0;
      posx     <= '0;
      wposx    <= '0;
    end else if (consume) begin
      width_q  <= cfg_w;
      bypass_q <= CFG_BYPASS;
      posy_q   <= pend_posy;
      posx     <= '0;
      wposx    <= '0;
    end else begin
      if (IN_DE)   posx  <= posx_inc;
      if (res_acc) wposx <= wposx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) overrun_q <= 1'b0;
    else        overrun_q <= overrun_q | q_drop | k_drop;
  end

  px_pack #(
    .NCH      (NCH),
    .HAS_ALPHA(HAS_ALPHA)
  ) u_pack (
    .clk     (CLK),
    .rst_n   (RST_N),
    .de      (res_acc),
    .ch      (px_ch),
    .alpha   (CFG_ALPHA),
    .out_de  (OUT_DE),
    .out_data(OUT_DATA)
  );

endmodule

// File: tb/tb_line_proc_sequencer.sv
// Scoreboard bench for line_proc_sequencer with a 3-cycle inverting kernel.
// Stimulus pushes expected pixels and line records; a negedge monitor checks them.
module tb_line_proc_sequencer;

  localparam int WB = 12;
  localparam int PW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [WB-1:0] CFG_WIDTH = '0;
  logic          CFG_BYPASS = 1'b0;
  logic [7:0]    CFG_ALPHA = 8'h3C;
  logic          READ_LINE_DONE = 1'b0;
  logic [WB-1:0] READ_POSY = '0;
  logic          IN_DE;
  logic [PW-1:0] IN_DATA;
  logic          K_READY;
  logic [WB-1:0] K_POSX, K_POSY;
  logic          K_RDEN;
  logic [23:0]   K_IN;
  logic          K_WREN;
  logic [23:0]   K_OUT;
  logic          OUT_DE;
  logic [PW-1:0] OUT_DATA;
  logic          WRITE_LINE_DONE, BUSY, OVERRUN;

  line_proc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .CFG_WIDTH(CFG_WIDTH), .CFG_BYPASS(CFG_BYPASS),
    .CFG_ALPHA(CFG_ALPHA),
    .READ_LINE_DONE(READ_LINE_DONE), .READ_POSY(READ_POSY),
    .IN_DE(IN_DE), .IN_DATA(IN_DATA),
    .K_READY(K_READY), .K_POSX(K_POSX), .K_POSY(K_POSY),
    .K_RDEN(K_RDEN), .K_IN(K_IN),
    .K_WREN(K_WREN), .K_OUT(K_OUT),
    .OUT_DE(OUT_DE), .OUT_DATA(OUT_DATA),
    .WRITE_LINE_DONE(WRITE_LINE_DONE),
    .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int width;
    int posy;
  } line_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_base = 0;
  int          kw_cnt = 0;
  logic [31:0] data_q[$];
  line_t       line_q[$];

  function automatic logic [31:0] pix(int i);
    logic [7:0] a;
    a = i[7:0];
    return {a, 8'(i * 3), ~a, 8'h5A};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source line buffer: pops on IN_DE.
  int src_idx;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N)     src_idx <= 0;
    else if (IN_DE) src_idx <= src_idx + 1;
  assign IN_DATA = pix(src_idx);

  // Kernel model: inverts channels, 3-cycle latency.
  logic            krd_en = 1'b1;
  logic            xtra = 1'b0;
  logic [2:0]      kv;
  logic [2:0][23:0] kd;
  assign K_RDEN = krd_en && K_READY;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      kv <= '0;
      kd <= '0;
    end else begin
      kv <= {kv[1:0], K_RDEN && IN_DE};
      kd <= {kd[1:0], ~K_IN};
    end
  assign K_WREN = kv[2] | xtra;
  assign K_OUT  = kd[2];
  always @(posedge CLK) if (K_WREN) kw_cnt <= kw_cnt + 1;

  // Monitor
  int    in_cnt = 0, out_cnt = 0;
  logic  prev_out_de = 1'b0, prev_wld = 1'b0;
  line_t cur;
  always @(negedge CLK) begin
    if (!RST_N) begin
      in_cnt = 0;
      out_cnt = 0;
      prev_out_de = 1'b0;
      prev_wld = 1'b0;
    end else begin
      if (IN_DE) begin
        chk("in_de_expected", 32'(line_q.size() > 0), 1);
        if (line_q.size() > 0) begin
          chk("k_posx", K_POSX, in_cnt);
          if (in_cnt == 0) chk("k_posy", K_POSY, line_q[0].posy);
        end
        in_cnt++;
      end
      if (OUT_DE) begin
        chk("out_de_expected", 32'(data_q.size() > 0), 1);
        if (data_q.size() > 0) chk("out_data", OUT_DATA, data_q.pop_front());
        out_cnt++;
      end
      if (WRITE_LINE_DONE) begin
        chk("wld_single", prev_wld, 0);
        chk("wld_after_last_out", prev_out_de, 1);
        chk("wld_expected", 32'(line_q.size() > 0), 1);
        if (line_q.size() > 0) begin
          cur = line_q.pop_front();
          chk("in_de_count", in_cnt, cur.width);
          chk("out_de_count", out_cnt, cur.width);
        end
        in_cnt = 0;
        out_cnt = 0;
      end
      prev_out_de = OUT_DE;
      prev_wld = WRITE_LINE_DONE;
    end
  end

  task automatic start_line(int w, bit byp, int posy, bit expect_it);
    int          ew;
    logic [31:0] p;
    @(negedge CLK);
    CFG_WIDTH = w[WB-1:0];
    CFG_BYPASS = byp;
    READ_POSY = posy[WB-1:0];
    READ_LINE_DONE = 1'b1;
    if (expect_it) begin
      ew = (w == 0 || w > 1600) ? 1600 : w;
      for (int i = 0; i < ew; i++) begin
        p = pix(exp_base + i);
        data_q.push_back(byp ? {p[31:8], CFG_ALPHA} : {~p[31:8], CFG_ALPHA});
      end
      line_q.push_back('{ew, posy});
      exp_base += ew;
    end
    @(negedge CLK);
    READ_LINE_DONE = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      done = !BUSY && line_q.size() == 0 && data_q.size() == 0;
    end
    chk("idle_reached", 32'(done), 1);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    data_q.delete();
    line_q.delete();
    exp_base = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int k0;
    int bad;
    repeat (3) @(negedge CLK);
    chk("reset_flags",
        32'({IN_DE, K_READY, OUT_DE, WRITE_LINE_DONE, BUSY, OVERRUN}), 0);
    chk("reset_pos", 32'({K_POSX, K_POSY}), 0);
    chk("reset_out_data", OUT_DATA, 0);
    RST_N = 1'b1;

    // T1: kernel mode, width 4, posy 7
    start_line(4, 1'b0, 7, 1'b1);
    wait_idle(100);
    chk("t1_overrun", OVERRUN, 0);

    // T2: bypass, width 8, alpha FF
    CFG_ALPHA = 8'hFF;
    start_line(8, 1'b1, 9, 1'b1);
    wait_idle(100);
    chk("t2_overrun", OVERRUN, 0);

    // T4: width 0 means the full 1600
    start_line(0, 1'b0, 20, 1'b1);
    wait_idle(2000);
    chk("t4_overrun", OVERRUN, 0);

    // T3: one queued event accepted, a third dropped
    start_line(4, 1'b0, 1, 1'b1);
    @(negedge CLK);
    start_line(4, 1'b0, 2, 1'b1);
    start_line(4, 1'b0, 3, 1'b0);
    for (int i = 0; i < 50 && !WRITE_LINE_DONE; i++) @(negedge CLK);
    chk("t3_first_done", WRITE_LINE_DONE, 1);
    @(negedge CLK);
    chk("t3_consume_cycle_busy", BUSY, 0);
    @(negedge CLK);
    chk("t3_second_busy", BUSY, 1);
    chk("t3_second_posy", K_POSY, 2);
    wait_idle(100);
    chk("t3_overrun", OVERRUN, 1);

    pulse_reset();
    chk("overrun_cleared", OVERRUN, 0);

    // T5: fifth kernel result for a 4-pixel line
    k0 = kw_cnt;
    start_line(4, 1'b0, 5, 1'b1);
    for (int i = 0; i < 50 && kw_cnt < k0 + 4; i++) @(negedge CLK);
    chk("t5_four_results", kw_cnt - k0, 4);
    xtra = 1'b1;
    @(negedge CLK);
    xtra = 1'b0;
    wait_idle(100);
    chk("t5_overrun", OVERRUN, 1);

    // T6: reset while POSX is 2
    start_line(8, 1'b0, 6, 1'b1);
    for (int i = 0; i < 50 && K_POSX != 2; i++) @(negedge CLK);
    chk("t6_posx_reached", K_POSX, 2);
    RST_N = 1'b0;
    data_q.delete();
    line_q.delete();
    exp_base = 0;
    #1;
    chk("t6_flags_zero",
        32'({IN_DE, K_READY, OUT_DE, WRITE_LINE_DONE, BUSY, OVERRUN}), 0);
    chk("t6_pos_zero", 32'({K_POSX, K_POSY}), 0);
    chk("t6_data_zero", OUT_DATA, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      bad += int'(BUSY | WRITE_LINE_DONE | OUT_DE | IN_DE);
    end
    chk("t6_stays_idle", bad, 0);
    start_line(3, 1'b0, 11, 1'b1);
    wait_idle(100);
    chk("t6_overrun", OVERRUN, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
